// File: rtl/alu_mult_sequencer.sv
// Shift-add unsigned multiplier that borrows the shared ALU.
// One ALU add per cycle, WIDTH iterations, then a one-cycle done.
module alu_mult_sequencer #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_AND = 4'b0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               aluOwn,
  output logic [WIDTH-1:0]   aluInputA,
  output logic [WIDTH-1:0]   aluInputB,
  output logic [3:0]         aluControl,
  input  logic [WIDTH-1:0]   aluResult
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;
  logic [CW-1:0]    count;
  logic             carry;

  always_comb begin
    aluInputA  = '0;
    aluInputB  = '0;
    aluControl = ALU_AND;
    if (state == RUN) begin
      aluInputA  = prod_hi;
      aluInputB  = prod_lo[0] ? mcand : '0;
      aluControl = ALU_ADD;
    end
  end

  // The ALU has no carry out; a wrapped sum is smaller than its operand.
  assign carry = (aluResult < prod_hi);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
      count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand   <= multiplicand;
            prod_lo <= multiplier;
            prod_hi <= '0;
            count   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          {prod_hi, prod_lo} <=
            {carry, aluResult, prod_lo[WIDTH-1:1]};
          count <= count + CW'(1);
          if (count == LAST) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign aluOwn  = (state == RUN);
  assign product = {prod_hi, prod_lo};

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Directed bench for alu_mult_sequencer with a behavioural ALU.
// Each task drives one scenario and checks its own results.
module tb_alu_mult_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic        aluOwn;
  logic [31:0] aluInputA;
  logic [31:0] aluInputB;
  logic [3:0]  aluControl;
  logic [31:0] aluResult;

  int total;
  int bad;

  alu_mult_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .aluOwn       (aluOwn),
    .aluInputA    (aluInputA),
    .aluInputB    (aluInputB),
    .aluControl   (aluControl),
    .aluResult    (aluResult)
  );

  assign aluResult = (aluControl == 4'b0010) ?
    aluInputA + aluInputB : aluInputA & aluInputB;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_mult(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p,
    output int          done_edge,
    output int          busy_cycles,
    output int          dones
  );
    int edges;
    bit finished;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    edges       = 1;
    busy_cycles = 0;
    dones       = 0;
    done_edge   = -1;
    p           = '0;
    finished    = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (busy) busy_cycles++;
      if (done) begin
        dones++;
        p = product;
        done_edge = edges;
      end
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      edges++;
    end
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL run_timeout a=%h b=%h still busy", a, b);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, aluOwn} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000",
               {busy, done, aluOwn});
    end
    total++;
    if (product !== 64'h0) begin
      bad++;
      $display("FAIL reset_product got=%h want=0", product);
    end
    total++;
    if ({aluInputA, aluInputB, aluControl} !== 68'h0) begin
      bad++;
      $display("FAIL reset_alu a=%h b=%h c=%h want 0",
               aluInputA, aluInputB, aluControl);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [63:0] p;
    int de, bc, nd;
    run_mult(32'd3, 32'd5, p, de, bc, nd);
    total++;
    if (p !== 64'h0000_0000_0000_000F) begin
      bad++;
      $display("FAIL basic_product got=%h want=f", p);
    end
    total++;
    if (de !== 33) begin
      bad++;
      $display("FAIL basic_latency got=%0d want=33", de);
    end
    total++;
    if (bc !== 33) begin
      bad++;
      $display("FAIL basic_busy got=%0d want=33", bc);
    end
    total++;
    if (nd !== 1) begin
      bad++;
      $display("FAIL basic_dones got=%0d want=1", nd);
    end
    total++;
    if (product !== 64'hF) begin
      bad++;
      $display("FAIL basic_hold got=%h want=f", product);
    end
  endtask

  task automatic test_vectors;
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [63:0] ve [4];
    logic [63:0] p;
    int de, bc, nd;
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF;
    ve[0] = 64'hFFFF_FFFE_0000_0001;
    va[1] = 32'h8000_0000; vb[1] = 32'd2;
    ve[1] = 64'h0000_0001_0000_0000;
    va[2] = 32'h0; vb[2] = 32'h1234_5678;
    ve[2] = 64'h0;
    va[3] = 32'h0001_0000; vb[3] = 32'h0001_0000;
    ve[3] = 64'h0000_0001_0000_0000;
    for (int i = 0; i < 4; i++) begin
      run_mult(va[i], vb[i], p, de, bc, nd);
      total++;
      if (p !== ve[i] || nd !== 1) begin
        bad++;
        $display("FAIL vector%0d got=%h dones=%0d want=%h",
                 i, p, nd, ve[i]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int nd;
    logic [63:0] p;
    @(negedge clk);
    multiplicand = 32'd9;
    multiplier   = 32'd11;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    multiplicand = 32'd100;
    multiplier   = 32'd200;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    p  = '0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        p = product;
      end
    end
    total++;
    if (p !== 64'd99) begin
      bad++;
      $display("FAIL ignore_product got=%h want=63", p);
    end
    total++;
    if (nd !== 1) begin
      bad++;
      $display("FAIL ignore_dones got=%0d want=1", nd);
    end
  endtask

  task automatic test_reset_midrun;
    int nd;
    logic [63:0] p;
    int de, bc, nd2;
    @(negedge clk);
    multiplicand = 32'd123;
    multiplier   = 32'd456;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, aluOwn} !== 3'b000 || product !== 64'h0) begin
      bad++;
      $display("FAIL midreset_outputs flags=%b prod=%h want 0",
               {busy, done, aluOwn}, product);
    end
    total++;
    if ({aluInputA, aluInputB, aluControl} !== 68'h0) begin
      bad++;
      $display("FAIL midreset_alu a=%h b=%h c=%h want 0",
               aluInputA, aluInputB, aluControl);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) nd++;
    end
    total++;
    if (nd !== 0) begin
      bad++;
      $display("FAIL midreset_nodone got=%0d want=0", nd);
    end
    run_mult(32'd7, 32'd6, p, de, bc, nd2);
    total++;
    if (p !== 64'd42 || nd2 !== 1) begin
      bad++;
      $display("FAIL midreset_restart got=%h dones=%0d want=2a",
               p, nd2);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] cur_a, cur_b, pend_a, pend_b;
    logic [63:0] exp;
    logic        prev_busy;
    int last_done, ndone, cyc, own_bad;
    pend_a = $urandom;
    pend_b = $urandom;
    cur_a  = '0;
    cur_b  = '0;
    @(negedge clk);
    multiplicand = pend_a;
    multiplier   = pend_b;
    start        = 1'b1;
    prev_busy = 1'b0;
    last_done = -1;
    ndone     = 0;
    own_bad   = 0;
    cyc       = 0;
    while (ndone < 5 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy && !prev_busy) begin
        cur_a  = pend_a;
        cur_b  = pend_b;
        pend_a = $urandom;
        pend_b = $urandom;
        multiplicand = pend_a;
        multiplier   = pend_b;
      end
      prev_busy = busy;
      if (aluOwn !== (busy && !done)) own_bad++;
      if (!aluOwn && aluControl !== 4'b0000) own_bad++;
      if (aluOwn && aluControl !== 4'b0010) own_bad++;
      if (done) begin
        exp = 64'(cur_a) * 64'(cur_b);
        total++;
        if (product !== exp) begin
          bad++;
          $display("FAIL b2b_product%0d got=%h want=%h",
                   ndone, product, exp);
        end
        if (last_done >= 0) begin
          total++;
          if (cyc - last_done !== 34) begin
            bad++;
            $display("FAIL b2b_period got=%0d want=34",
                     cyc - last_done);
          end
        end
        last_done = cyc;
        ndone++;
      end
    end
    start = 1'b0;
    total++;
    if (ndone !== 5) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=5", ndone);
    end
    total++;
    if (own_bad !== 0) begin
      bad++;
      $display("FAIL b2b_aluown errors=%0d want=0", own_bad);
    end
    repeat (40) @(posedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_basic;
    test_vectors;
    test_ignore_start;
    test_reset_midrun;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
